alu_reg_file: RTL and testbench
===============================

# alu_reg_file

Register file and flag stage wrapped around the 16-bit ALU of the MicroEV20 datapath. It holds eight 16-bit general registers. Two asynchronous read ports drive the ALU operand inputs A and B. One synchronous write port captures either the ALU result Z or an external bus word. A carry flag register captures the ALU carryOut and feeds it back as carryIn, and a zero flag register records whether the last written value was zero. All writes and flag updates are commanded each cycle by the microcode control word.

## Interface
Parameters:
- WIDTH, 16, data width; must match the ALU width.
- NREGS, 8, number of general registers; a power of two.
- SELW, 3, register select width, equal to log2(NREGS).

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- selA  input  SELW  register index driven onto aluA.
- selB  input  SELW  register index driven onto aluB.
- selW  input  SELW  register index written on a write cycle.
- we  input  1  write enable for register selW.
- wrSrc  input  1  write data source; 0 selects aluZ, 1 selects busIn.
- aluZ  input  WIDTH  ALU result.
- busIn  input  WIDTH  external data (memory/immediate) for loads.
- weC  input  1  carry flag update enable.
- aluCarry  input  1  ALU carryOut.
- aluA  output  WIDTH  operand A, equal to reg[selA].
- aluB  output  WIDTH  operand B, equal to reg[selB].
- carryFlag  output  1  registered carry; connects to ALU carryIn.
- zeroFlag  output  1  registered zero flag.
- busOut  output  WIDTH  equal to reg[selB]; used for stores.

## Operation
- **Reads**
  - Combinational: aluA = reg[selA], aluB = busOut = reg[selB].
  - There is no write-to-read bypass. A read returns the contents held before the current edge.
- **Write**
  - Trigger: rising edge with we=1.
  - Write data is wd = wrSrc ? busIn : aluZ.
  - Action: reg[selW] <= wd and zeroFlag <= (wd == 0).
  - With we=0, no register changes and zeroFlag holds.
- **Carry**
  - Trigger: rising edge with weC=1.
  - Action: carryFlag <= aluCarry, independent of we and wrSrc.
  - With weC=0, carryFlag holds.
  - The ALU's own clear-carry and set-carry operations reach this flag only through weC=1.
- **Simultaneous events**
  - we and weC in the same cycle: both updates occur.
  - selA == selB: both ports show the same register.
  - selW equal to selA or selB: the write takes effect after the edge, so the new value is visible in the next cycle.
- **Reset**
  - While rst_n=0, all registers, carryFlag and zeroFlag are cleared asynchronously. zeroFlag resets to 0.
  - Outputs therefore read 0 during reset, and all writes are ignored while rst_n=0.
  - Asserting reset mid-cycle clears state immediately, without waiting for clk.
  - Deassertion is synchronised externally. The first write is accepted on the first rising edge with rst_n=1.
- **Width rules**
  - No arithmetic is performed here; data passes through at WIDTH bits.
  - Select inputs are decoded fully. With NREGS = 2^SELW there are no out-of-range indices.

## Timing
- Read path: select change to aluA/aluB/busOut is purely combinational, with zero cycles of latency.
- Write path: one edge. Data present with we=1 at edge N is readable from edge N onward, i.e. in cycle N+1.
- Flag path: one edge. carryFlag presented to the ALU in cycle N+1 reflects aluCarry sampled at edge N. This makes the ALU add-with-carry operation chainable every cycle.
- Combinational loop constraint: the path aluA/aluB -> ALU -> aluZ -> wd must end only at register D inputs, never at read mux outputs.
- No handshake: the microsequencer guarantees one command per cycle, and there is no stall.

## Test plan
- **Reset:** assert rst_n=0 asynchronously mid-cycle after loading values -> all registers read 0x0000, carryFlag=0, zeroFlag=0 before the next edge.
- **Load then read:** wrSrc=1, busIn=0x1234, selW=3, we=1; next cycle selA=3, selB=3 -> aluA=aluB=busOut=0x1234, zeroFlag=0.
- **No bypass:** in the cycle writing reg2 from 0x0000 to 0xBEEF with selA=2 -> aluA=0x0000 in that cycle and 0xBEEF in the following cycle.
- **Carry chain:** sum 0xFFFF+0x0001 with we=1, selW=1, weC=1, aluCarry=1 -> reg1=0x0000, zeroFlag=1, carryFlag=1. Next cycle carryFlag drives carryIn, and a carry-sum of 0x0000+0x0000 written to reg2 gives 0x0001, zeroFlag=0.
- **Flag holds:** we=0, weC=0 for 3 cycles with aluZ=0 and aluCarry toggling -> registers, carryFlag and zeroFlag are unchanged.
- **Simultaneous select:** selA=selB=selW=5, we=1, aluZ=0x00FF -> both read ports show the old value, then 0x00FF after the edge. A sweep writing every index 0..7 with distinct values reads all of them back correctly.

Source files
------------

// File: rtl/alu_reg_file_if.sv
// alu_reg_file_if: microcode command, ALU operand and flag signals of the register/flag stage
interface alu_reg_file_if #(
    parameter int WIDTH = 16,
    parameter int SELW  = 3
);
    logic [SELW-1:0]  selA, selB, selW;
    logic             we, wrSrc, weC, aluCarry;
    logic [WIDTH-1:0] aluZ, busIn;
    logic [WIDTH-1:0] aluA, aluB, busOut;
    logic             carryFlag, zeroFlag;
    modport master (
        output selA, selB, selW, we, wrSrc, aluZ, busIn, weC, aluCarry,
        input  aluA, aluB, busOut, carryFlag, zeroFlag
    );
    modport slave (
        input  selA, selB, selW, we, wrSrc, aluZ, busIn, weC, aluCarry,
        output aluA, aluB, busOut, carryFlag, zeroFlag
    );
endinterface

// File: rtl/alu_reg_file.sv
// alu_reg_file: eight-entry register file with async reads, one sync write port and carry/zero flags
module alu_reg_file #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int SELW  = 3
) (
    input logic         clk,
    input logic         rst_n,
    alu_reg_file_if.slave bus
);
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic             carry_q, carry_d, zero_q, zero_d;
    logic [WIDTH-1:0] wd;
    always_comb begin
        wd = bus.wrSrc ? bus.busIn : bus.aluZ;
        for (int i = 0; i < NREGS; i++)
            regs_d[i] = (bus.we && bus.selW == SELW'(i)) ? wd : regs_q[i];
        zero_d  = bus.we ? (wd == '0) : zero_q;
        carry_d = bus.weC ? bus.aluCarry : carry_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                regs_q[i] <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end
    // reads come straight from the flops, so aluZ can never loop back into aluA/aluB
    assign bus.aluA      = regs_q[bus.selA];
    assign bus.aluB      = regs_q[bus.selB];
    assign bus.busOut    = regs_q[bus.selB];
    assign bus.carryFlag = carry_q;
    assign bus.zeroFlag  = zero_q;
endmodule

// File: tb/tb_alu_reg_file.sv
// tb_alu_reg_file: table vectors, directed corner sequences and random traffic against an array model
module tb_alu_reg_file;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_reg_file_if #(.WIDTH(16), .SELW(3)) bif ();
    alu_reg_file #(.WIDTH(16), .NREGS(8), .SELW(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bif.slave));

    int n_pass = 0;
    int n_total = 0;
    logic [15:0] mreg [8];
    logic mc, mz;

    typedef struct {
        logic        we, wrSrc;
        logic [2:0]  selW;
        logic [15:0] bus_in, z;
        logic        weC, cin;
        logic [15:0] exp_reg;
        logic        exp_z, exp_c;
    } vec_t;
    vec_t tbl [9];

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic idle();
        bif.selA = 0; bif.selB = 0; bif.selW = 0; bif.we = 0; bif.wrSrc = 0;
        bif.aluZ = 0; bif.busIn = 0; bif.weC = 0; bif.aluCarry = 0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) mreg[i] = 16'h0;
        mc = 1'b0; mz = 1'b0;
    endtask

    task automatic edge_step();
        logic [15:0] wd;
        @(posedge clk);
        wd = bif.wrSrc ? bif.busIn : bif.aluZ;
        if (!rst_n) model_clear();
        else begin
            if (bif.we) begin mreg[bif.selW] = wd; mz = (wd == 16'h0); end
            if (bif.weC) mc = bif.aluCarry;
        end
        #1;
    endtask

    task automatic chk_reads(input string tag);
        chk({tag, "_aluA"}, bif.aluA, mreg[bif.selA]);
        chk({tag, "_aluB"}, bif.aluB, mreg[bif.selB]);
        chk({tag, "_busOut"}, bif.busOut, mreg[bif.selB]);
    endtask

    task automatic write(input logic [2:0] sel, input logic [15:0] d);
        bif.we = 1; bif.wrSrc = 1; bif.selW = sel; bif.busIn = d;
        edge_step();
        idle();
    endtask

    initial begin
        logic [16:0] sum;
        tbl[0] = '{1'b1, 1'b1, 3'd3, 16'h1234, 16'h0000, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 3'd1, 16'h5555, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 3'd2, 16'h0000, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 3'd3, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 3'd3, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 3'd4, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 3'd4, 16'h0000, 16'h1111, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1};
        tbl[7] = '{1'b1, 1'b0, 3'd7, 16'h0000, 16'hBEEF, 1'b0, 1'b0, 16'hBEEF, 1'b0, 1'b1};
        tbl[8] = '{1'b1, 1'b0, 3'd6, 16'hABCD, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        idle();
        model_clear();
        #12;
        for (int i = 0; i < 8; i++) begin
            bif.selA = 3'(i); bif.selB = 3'(7 - i); #1;
            chk("reset_aluA", bif.aluA, 16'h0);
            chk("reset_busOut", bif.busOut, 16'h0);
        end
        chk("reset_carry", {15'h0, bif.carryFlag}, 16'h0);
        chk("reset_zero", {15'h0, bif.zeroFlag}, 16'h0);
        idle();
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int k = 0; k < 9; k++) begin
            bif.we = tbl[k].we; bif.wrSrc = tbl[k].wrSrc; bif.selW = tbl[k].selW;
            bif.busIn = tbl[k].bus_in; bif.aluZ = tbl[k].z; bif.weC = tbl[k].weC; bif.aluCarry = tbl[k].cin;
            edge_step();
            idle();
            bif.selA = tbl[k].selW; #1;
            chk($sformatf("vec%0d_reg", k), bif.aluA, tbl[k].exp_reg);
            chk($sformatf("vec%0d_zero", k), {15'h0, bif.zeroFlag}, {15'h0, tbl[k].exp_z});
            chk($sformatf("vec%0d_carry", k), {15'h0, bif.carryFlag}, {15'h0, tbl[k].exp_c});
        end

        // async reset mid-cycle with reg7=BEEF, reg3=1234, carry=1, zero=1
        @(posedge clk); #2;
        bif.selA = 7; bif.selB = 3;
        rst_n = 1'b0; #1;
        chk("async_rst_aluA", bif.aluA, 16'h0);
        chk("async_rst_aluB", bif.aluB, 16'h0);
        chk("async_rst_carry", {15'h0, bif.carryFlag}, 16'h0);
        chk("async_rst_zero", {15'h0, bif.zeroFlag}, 16'h0);
        bif.we = 1; bif.wrSrc = 1; bif.selW = 7; bif.busIn = 16'hFFFF; bif.weC = 1; bif.aluCarry = 1;
        edge_step();
        chk("rst_ignore_write", bif.aluA, 16'h0);
        chk("rst_ignore_carry", {15'h0, bif.carryFlag}, 16'h0);
        idle();
        rst_n = 1'b1;
        model_clear();

        // no bypass: write reg2 while reading it
        bif.we = 1; bif.wrSrc = 1; bif.busIn = 16'hBEEF; bif.selW = 2; bif.selA = 2; #1;
        chk("nobypass_before", bif.aluA, 16'h0000);
        edge_step();
        chk("nobypass_after", bif.aluA, 16'hBEEF);
        idle();

        // carry chain with the bench acting as the ALU
        write(3, 16'hFFFF);
        write(4, 16'h0001);
        bif.selA = 3; bif.selB = 4; #1;
        sum = {1'b0, bif.aluA} + {1'b0, bif.aluB} + {16'h0, bif.carryFlag};
        bif.we = 1; bif.wrSrc = 0; bif.selW = 1; bif.aluZ = sum[15:0]; bif.weC = 1; bif.aluCarry = sum[16];
        edge_step();
        idle(); bif.selA = 1; #1;
        chk("chain1_reg1", bif.aluA, 16'h0000);
        chk("chain1_zero", {15'h0, bif.zeroFlag}, 16'h1);
        chk("chain1_carry", {15'h0, bif.carryFlag}, 16'h1);
        bif.selA = 0; bif.selB = 6; #1;
        sum = {1'b0, bif.aluA} + {1'b0, bif.aluB} + {16'h0, bif.carryFlag};
        bif.we = 1; bif.wrSrc = 0; bif.selW = 2; bif.aluZ = sum[15:0]; bif.weC = 1; bif.aluCarry = sum[16];
        edge_step();
        idle(); bif.selA = 2; #1;
        chk("chain2_reg2", bif.aluA, 16'h0001);
        chk("chain2_zero", {15'h0, bif.zeroFlag}, 16'h0);
        chk("chain2_carry", {15'h0, bif.carryFlag}, 16'h0);

        // flags hold: set carry=1 zero=1, then idle with aluCarry toggling
        bif.we = 1; bif.selW = 1; bif.aluZ = 16'h0; bif.weC = 1; bif.aluCarry = 1;
        edge_step();
        idle();
        for (int c = 0; c < 3; c++) begin
            bif.aluCarry = c[0]; bif.selA = 2; bif.selB = 3;
            edge_step();
            chk("hold_reg2", bif.aluA, 16'h0001);
            chk("hold_reg3", bif.aluB, 16'hFFFF);
            chk("hold_carry", {15'h0, bif.carryFlag}, 16'h1);
            chk("hold_zero", {15'h0, bif.zeroFlag}, 16'h1);
        end
        idle();

        // selA == selB == selW
        bif.selA = 5; bif.selB = 5; bif.selW = 5; bif.we = 1; bif.aluZ = 16'h00FF; #1;
        chk("same_sel_before_A", bif.aluA, 16'h0000);
        chk("same_sel_before_B", bif.aluB, 16'h0000);
        edge_step();
        chk("same_sel_after_A", bif.aluA, 16'h00FF);
        chk("same_sel_after_bus", bif.busOut, 16'h00FF);
        idle();

        for (int i = 0; i < 8; i++) write(3'(i), 16'hA000 + 16'(i) * 16'h0111);
        for (int i = 0; i < 8; i++) begin
            bif.selA = 3'(i); bif.selB = 3'(7 - i); #1;
            chk($sformatf("sweep_A%0d", i), bif.aluA, 16'hA000 + 16'(i) * 16'h0111);
            chk($sformatf("sweep_B%0d", 7 - i), bif.busOut, 16'hA000 + 16'(7 - i) * 16'h0111);
        end

        for (int n = 0; n < 400; n++) begin
            bif.selA = 3'($urandom); bif.selB = 3'($urandom); bif.selW = 3'($urandom);
            bif.we = 1'($urandom); bif.wrSrc = 1'($urandom);
            bif.aluZ = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            bif.busIn = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            bif.weC = 1'($urandom); bif.aluCarry = 1'($urandom);
            #1;
            chk_reads("rand");
            edge_step();
            chk("rand_carry", {15'h0, bif.carryFlag}, {15'h0, mc});
            chk("rand_zero", {15'h0, bif.zeroFlag}, {15'h0, mz});
        end
        idle();
        for (int i = 0; i < 8; i++) begin
            bif.selA = 3'(i); bif.selB = 3'(i ^ 1); #1;
            chk_reads("final");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
